// File: rtl/riscv_pkg.sv
// Shared write-back types: data width, register index and the FIFO entry that
// carries a pending load result to the register file.
package riscv_pkg;

    localparam int XLEN = 64;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries. Holds load results that lost
// arbitration to the ALU until the output register is free.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally modulo DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    assign head  = entries[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: arbitrates ALU results, queued loads and bypassed loads into
// one registered register-file write per cycle, and tracks pending writers.
module regfile_writeback #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [4:0]        mem_rd,
    input  logic [XLEN-1:0]   mem_data,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    output logic [31:0]       busy,
    output logic              reg_write,
    output logic [4:0]        rd,
    output logic [XLEN-1:0]   write_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    riscv_pkg::wb_entry_t alu_entry;
    riscv_pkg::wb_entry_t mem_entry;
    riscv_pkg::wb_entry_t head;
    riscv_pkg::wb_entry_t sel_entry;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    logic             accept;
    logic             sel_valid;
    logic             push;
    logic             pop;
    logic             launch;
    logic [31:0]      busy_next;

    assign alu_entry.rd   = alu_rd;
    assign alu_entry.data = alu_data;
    assign mem_entry.rd   = mem_rd;
    assign mem_entry.data = mem_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (mem_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Priority: ALU, then oldest queued load, then a load that can skip the queue.
    always_comb begin
        accept    = mem_valid && mem_ready;
        sel_valid = 1'b0;
        sel_entry = alu_entry;
        push      = 1'b0;
        pop       = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            push      = accept;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_entry = head;
            pop       = 1'b1;
            push      = accept;
        end else if (accept) begin
            sel_valid = 1'b1;
            sel_entry = mem_entry;
        end
        launch     = sel_valid && (sel_entry.rd != '0);
        count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

        // Clear first so a same-cycle issue to the same register keeps it busy.
        busy_next = busy;
        if (launch) begin
            busy_next[sel_entry.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    // Output register stage; ready looks only at next occupancy, never at this cycle's valids.
    always_ff @(posedge clock) begin
        if (!reset) begin
            reg_write  <= 1'b0;
            rd         <= '0;
            write_data <= '0;
            busy       <= '0;
            mem_ready  <= 1'b0;
        end else begin
            reg_write <= launch;
            rd        <= launch ? sel_entry.rd : '0;
            if (launch) begin
                write_data <= sel_entry.data;
            end
            busy      <= busy_next;
            mem_ready <= (count_next != CNT_W'(DEPTH));
        end
    end

    // Unused when the FIFO never signals full to the arbiter directly.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes are queued as stimulus
// is driven and popped by a monitor whenever the DUT launches a write.
module tb_regfile_writeback;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] busy;
    logic        reg_write;
    logic [4:0]  rd;
    logic [63:0] write_data;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    regfile_writeback #(
        .XLEN  (64),
        .DEPTH (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy        (busy),
        .reg_write   (reg_write),
        .rd          (rd),
        .write_data  (write_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] r, input logic [63:0] d);
        exp_t e;
        e.rd   = r;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Every launched write must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_write observed rd=%0d data=%0h expected no write", rd, write_data);
                end
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_rd", 64'(rd), 64'(e.rd));
                chk("sb_data", write_data, e.data);
            end
        end
    end

    initial begin
        // Reset held with every valid asserted
        reset = 1'b0; alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'd1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'd2;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        tick();
        chk("rst_reg_write", 64'(reg_write), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_write_data", write_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_ready", 64'(mem_ready), 64'd0);
        reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
        tick();
        chk("rel_mem_ready", 64'(mem_ready), 64'd1);
        chk("rel_reg_write", 64'(reg_write), 64'd0);

        // ALU path with scoreboard set and clear
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        chk("alu_busy_set", 64'(busy), 64'h20);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
        push_exp(5'd5, 64'hDEAD_BEEF);
        tick();
        alu_valid = 1'b0;
        chk("alu_reg_write", 64'(reg_write), 64'd1);
        chk("alu_rd", 64'(rd), 64'd5);
        chk("alu_data", write_data, 64'hDEAD_BEEF);
        chk("alu_busy_clr", 64'(busy), 64'd0);

        // ALU and load collide
        chk("col_ready", 64'(mem_ready), 64'd1);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h11;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'h22;
        push_exp(5'd3, 64'h11);
        push_exp(5'd4, 64'h22);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("col_first_rd", 64'(rd), 64'd3);
        tick();
        chk("col_second_we", 64'(reg_write), 64'd1);
        chk("col_second_rd", 64'(rd), 64'd4);
        tick();
        chk("col_idle", 64'(reg_write), 64'd0);

        // Backpressure: ALU stream fills the FIFO
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'(100 + i);
            mem_valid = 1'b1; mem_rd = 5'(20 + i); mem_data = 64'h1000 + 64'(i);
            chk("bp_ready_open", 64'(mem_ready), 64'd1);
            push_exp(5'd10, 64'(100 + i));
            tick();
        end
        chk("bp_full_ready", 64'(mem_ready), 64'd0);
        alu_data = 64'd104; mem_rd = 5'd24; mem_data = 64'h1004;
        push_exp(5'd10, 64'd104);
        tick();
        chk("bp_still_full", 64'(mem_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            push_exp(5'(20 + i), 64'h1000 + 64'(i));
        end
        alu_valid = 1'b0;
        tick();
        chk("bp_drain0_rd", 64'(rd), 64'd20);
        chk("bp_ready_back", 64'(mem_ready), 64'd1);
        push_exp(5'd24, 64'h1004);
        tick();
        mem_valid = 1'b0;
        chk("bp_drain1_rd", 64'(rd), 64'd21);
        for (int i = 2; i < 5; i++) begin
            tick();
            chk("bp_drain_rd", 64'(rd), 64'(20 + i));
        end
        tick();
        chk("bp_idle", 64'(reg_write), 64'd0);

        // x0 handling and set-beats-clear
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        chk("x0_busy", 64'(busy), 64'd0);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h55;
        tick();
        alu_valid = 1'b0;
        chk("x0_reg_write", 64'(reg_write), 64'd0);
        chk("x0_rd", 64'(rd), 64'd0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        chk("sb7_set", 64'(busy), 64'h80);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
        push_exp(5'd7, 64'h77);
        tick();
        issue_valid = 1'b0;
        chk("sb7_write_rd", 64'(rd), 64'd7);
        chk("sb7_set_wins", 64'(busy), 64'h80);
        alu_data = 64'h78;
        push_exp(5'd7, 64'h78);
        tick();
        alu_valid = 1'b0;
        chk("sb7_cleared", 64'(busy), 64'd0);

        // Reset while loads are queued
        issue_valid = 1'b1; issue_rd = 5'd12;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'(200 + i);
            mem_valid = 1'b1; mem_rd = 5'(25 + i); mem_data = 64'h2000 + 64'(i);
            push_exp(5'd2, 64'(200 + i));
            tick();
            issue_valid = 1'b0;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("mid_busy_before", 64'(busy), 64'h1000);
        reset = 1'b0;
        tick();
        chk("mid_rst_we", 64'(reg_write), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(mem_ready), 64'd0);
        reset = 1'b1;
        tick();
        chk("mid_rel_ready", 64'(mem_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_stale", 64'(reg_write), 64'd0);
            tick();
        end

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
